// File: rtl/reflet_timer_multi_pkg.sv
// Shared definitions for the multi-channel Reflet interval timer:
// per-channel register offsets, CTRL bit layout and the CTRL record type.
package reflet_timer_multi_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_RELOAD   = 2'd2;
  localparam logic [1:0] REG_COUNT    = 2'd3;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_FLAG    = 3;

  // Field order matches the CTRL bit positions above (flag is the MSB).
  typedef struct packed {
    logic flag;
    logic irq_en;
    logic oneshot;
    logic run;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_word(input logic [3:0] word);
    ctrl_t c;
    c.run     = word[CTRL_RUN];
    c.oneshot = word[CTRL_ONESHOT];
    c.irq_en  = word[CTRL_IRQ_EN];
    c.flag    = word[CTRL_FLAG];
    return c;
  endfunction

  function automatic logic [3:0] ctrl_to_word(input ctrl_t c);
    logic [3:0] word;
    word               = 4'd0;
    word[CTRL_RUN]     = c.run;
    word[CTRL_ONESHOT] = c.oneshot;
    word[CTRL_IRQ_EN]  = c.irq_en;
    word[CTRL_FLAG]    = c.flag;
    return word;
  endfunction

endpackage

// File: rtl/reflet_timer_multi_if.sv
// Reflet system-bus register port used by the timer block.
interface reflet_timer_multi_if #(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 16
);
  logic                      enable;
  logic [base_addr_size-1:0] addr;
  logic                      write_en;
  logic [wordsize-1:0]       data_in;
  logic [wordsize-1:0]       data_out;

  modport master (
    output enable,
    output addr,
    output write_en,
    output data_in,
    input  data_out
  );

  modport slave (
    input  enable,
    input  addr,
    input  write_en,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/reflet_timer_multi_channel.sv
// One timer channel: CTRL/PRESCALE/RELOAD registers, prescaler and main
// counter, sticky event flag, and the channel's register read mux.
module reflet_timer_channel
  import reflet_timer_multi_pkg::*;
#(
  parameter int wordsize  = 16,
  parameter int cnt_width = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic [1:0]          reg_sel,
  input  logic                write_en,
  input  logic [wordsize-1:0] data_in,
  output logic [wordsize-1:0] rdata,
  output logic                irq
);

  ctrl_t                ctrl_r;
  logic [cnt_width-1:0] prescale_r;
  logic [cnt_width-1:0] reload_r;
  logic [cnt_width-1:0] pre_cnt_r;
  logic [cnt_width-1:0] count_r;

  ctrl_t                wr_ctrl_val_s;
  logic [cnt_width-1:0] wr_reg_val_s;
  logic                 wr_ctrl_s;
  logic                 wr_pre_s;
  logic                 wr_rel_s;
  logic                 active_s;
  logic                 tick_s;
  logic                 event_s;
  logic                 restart_s;

  assign wr_ctrl_val_s = ctrl_from_word(data_in[3:0]);
  assign wr_reg_val_s  = data_in[cnt_width-1:0];

  assign wr_ctrl_s = sel && write_en && (reg_sel == REG_CTRL);
  assign wr_pre_s  = sel && write_en && (reg_sel == REG_PRESCALE);
  assign wr_rel_s  = sel && write_en && (reg_sel == REG_RELOAD);

  assign active_s = ctrl_r.run && (reload_r != {cnt_width{1'b0}});
  assign tick_s   = active_s && (pre_cnt_r == prescale_r);
  assign event_s  = tick_s && (count_r == (reload_r - cnt_width'(1)));

  // Only a 0->1 run transition restarts; rewriting CTRL while running does not.
  assign restart_s = wr_pre_s || wr_rel_s ||
                     (wr_ctrl_s && !ctrl_r.run && wr_ctrl_val_s.run);

  assign irq = ctrl_r.flag && ctrl_r.irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_r <= {cnt_width{1'b0}};
      reload_r   <= {cnt_width{1'b0}};
      pre_cnt_r  <= {cnt_width{1'b0}};
      count_r    <= {cnt_width{1'b0}};
    end else begin
      if (wr_pre_s) begin
        prescale_r <= wr_reg_val_s;
      end
      if (wr_rel_s) begin
        reload_r <= wr_reg_val_s;
      end
      if (restart_s || !active_s) begin
        pre_cnt_r <= {cnt_width{1'b0}};
        count_r   <= {cnt_width{1'b0}};
      end else if (tick_s) begin
        pre_cnt_r <= {cnt_width{1'b0}};
        count_r   <= event_s ? {cnt_width{1'b0}} : (count_r + cnt_width'(1));
      end else begin
        pre_cnt_r <= pre_cnt_r + cnt_width'(1);
      end
    end
  end

  // A CTRL write overrides the one-shot stop; a set event beats a flag clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_r <= '0;
    end else begin
      if (wr_ctrl_s) begin
        ctrl_r.run     <= wr_ctrl_val_s.run;
        ctrl_r.oneshot <= wr_ctrl_val_s.oneshot;
        ctrl_r.irq_en  <= wr_ctrl_val_s.irq_en;
      end else if (event_s && ctrl_r.oneshot) begin
        ctrl_r.run <= 1'b0;
      end
      if (event_s) begin
        ctrl_r.flag <= 1'b1;
      end else if (wr_ctrl_s && wr_ctrl_val_s.flag) begin
        ctrl_r.flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = {wordsize{1'b0}};
    if (sel) begin
      case (reg_sel)
        REG_CTRL:     rdata[3:0]           = ctrl_to_word(ctrl_r);
        REG_PRESCALE: rdata[cnt_width-1:0] = prescale_r;
        REG_RELOAD:   rdata[cnt_width-1:0] = reload_r;
        REG_COUNT:    rdata[cnt_width-1:0] = count_r;
        default:      rdata                = {wordsize{1'b0}};
      endcase
    end else begin
      rdata = {wordsize{1'b0}};
    end
  end

endmodule

// File: rtl/reflet_timer_multi.sv
// Multi-channel memory-mapped interval timer: decodes the bus window into
// per-channel register selects, merges read data and registers the IRQ OR.
module reflet_timer_multi
  import reflet_timer_multi_pkg::*;
#(
  parameter int                        wordsize       = 16,
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF10,
  parameter int                        channels       = 2,
  parameter int                        cnt_width      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  reflet_timer_multi_if.slave         bus,
  output logic                        interrupt
);

  localparam int AW1   = base_addr_size + 1;
  localparam int IDX_W = base_addr_size - 2;
  localparam logic [AW1-1:0] WIN_LO = {1'b0, base_addr};
  localparam logic [AW1-1:0] WIN_HI = WIN_LO + AW1'(4 * channels);

  logic [AW1-1:0]            addr_ext_s;
  logic                      in_range_s;
  logic [base_addr_size-1:0] off_s;
  logic [channels-1:0]       sel_s;
  logic [channels-1:0]       irq_s;
  logic [wordsize-1:0]       rd_s [channels];
  logic [wordsize-1:0]       rd_or_s;

  // Compare one bit wider so a window ending at the top of the space works.
  assign addr_ext_s = {1'b0, bus.addr};
  assign in_range_s = bus.enable && (addr_ext_s >= WIN_LO) && (addr_ext_s < WIN_HI);
  assign off_s      = bus.addr - base_addr;

  for (genvar i = 0; i < channels; i++) begin : g_ch
    assign sel_s[i] = in_range_s && (off_s[base_addr_size-1:2] == IDX_W'(i));

    reflet_timer_channel #(
      .wordsize (wordsize),
      .cnt_width(cnt_width)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .sel     (sel_s[i]),
      .reg_sel (off_s[1:0]),
      .write_en(bus.write_en),
      .data_in (bus.data_in),
      .rdata   (rd_s[i]),
      .irq     (irq_s[i])
    );
  end

  always_comb begin
    rd_or_s = {wordsize{1'b0}};
    for (int i = 0; i < channels; i++) begin
      rd_or_s = rd_or_s | rd_s[i];
    end
  end

  assign bus.data_out = rd_or_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interrupt <= 1'b0;
    end else begin
      interrupt <= |irq_s;
    end
  end

endmodule

// File: tb/tb_reflet_timer_multi.sv
// Directed bench for reflet_timer_multi: register table plus hand-timed
// sequences for periodic, one-shot, collision, boundary and reset behaviour.
module tb_reflet_timer_multi;

  logic clk = 1'b0;
  logic reset;
  logic interrupt;

  reflet_timer_multi_if #(.wordsize(16), .base_addr_size(16)) bus ();

  reflet_timer_multi #(
    .wordsize      (16),
    .base_addr_size(16),
    .base_addr     (16'hFF10),
    .channels      (2),
    .cnt_width     (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        w_en;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic        r_en;
    logic [15:0] r_addr;
    logic [15:0] r_exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [15:0] a, input logic [15:0] d);
    bus.enable   = en;
    bus.addr     = a;
    bus.write_en = 1'b1;
    bus.data_in  = d;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.enable   = 1'b0;
  endtask

  task automatic rd(input logic en, input logic [15:0] a, output logic [15:0] v);
    bus.enable   = en;
    bus.write_en = 1'b0;
    bus.addr     = a;
    #1;
    v = bus.data_out;
    bus.enable = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] v;
    rd(1'b1, a, v);
    check(name, v, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {15'd0, interrupt}, {15'd0, exp});
  endtask

  initial begin
    logic [15:0] v;

    vecs[0]  = '{1'b1, 16'hFF11, 16'h1234, 1'b1, 16'hFF11, 16'h1234};
    vecs[1]  = '{1'b1, 16'hFF12, 16'h00AB, 1'b1, 16'hFF12, 16'h00AB};
    vecs[2]  = '{1'b0, 16'hFF12, 16'hFFFF, 1'b1, 16'hFF12, 16'h00AB};
    vecs[3]  = '{1'b1, 16'hFF10, 16'hFFF6, 1'b1, 16'hFF10, 16'h0006};
    vecs[4]  = '{1'b1, 16'hFF13, 16'h5555, 1'b1, 16'hFF13, 16'h0000};
    vecs[5]  = '{1'b1, 16'hFF15, 16'h0007, 1'b1, 16'hFF15, 16'h0007};
    vecs[6]  = '{1'b1, 16'hFF16, 16'h0009, 1'b1, 16'hFF16, 16'h0009};
    vecs[7]  = '{1'b1, 16'hFF11, 16'h0000, 1'b1, 16'hFF15, 16'h0007};
    vecs[8]  = '{1'b1, 16'hFF18, 16'hBEEF, 1'b1, 16'hFF18, 16'h0000};
    vecs[9]  = '{1'b1, 16'hFF17, 16'h1111, 1'b0, 16'hFF15, 16'h0000};
    vecs[10] = '{1'b1, 16'hFF10, 16'h0008, 1'b1, 16'hFF10, 16'h0000};
    vecs[11] = '{1'b1, 16'hFF14, 16'h0000, 1'b1, 16'hFF14, 16'h0000};

    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.addr     = 16'h0000;
    bus.write_en = 1'b0;
    bus.data_in  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int r = 0; r < 8; r++) begin
      chk_rd($sformatf("reset_reg%0d", r), 16'hFF10 + 16'(r), 16'h0000);
    end
    chk_irq("reset_irq", 1'b0);

    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].w_en, vecs[i].w_addr, vecs[i].w_data);
      rd(vecs[i].r_en, vecs[i].r_addr, v);
      check($sformatf("vec%0d", i), v, vecs[i].r_exp);
    end

    // Periodic ch0: PRESCALE=1, RELOAD=3, events every 6 cycles.
    wr(1'b1, 16'hFF11, 16'h0001);
    wr(1'b1, 16'hFF12, 16'h0003);
    wr(1'b1, 16'hFF10, 16'h0005);
    for (int k = 0; k < 6; k++) begin
      chk_rd($sformatf("per_count%0d", k), 16'hFF13, 16'(k / 2));
      step(1);
    end
    chk_rd("per_flag_set", 16'hFF10, 16'h000D);
    chk_irq("per_irq_not_yet", 1'b0);
    step(1);
    chk_irq("per_irq_rise", 1'b1);
    step(4);
    chk_irq("per_irq_held", 1'b1);
    chk_rd("per_count_pre_evt", 16'hFF13, 16'h0002);

    // Flag clear in the exact cycle of the second event: set wins.
    wr(1'b1, 16'hFF10, 16'h000D);
    chk_rd("coll_flag", 16'hFF10, 16'h000D);
    chk_rd("coll_count", 16'hFF13, 16'h0000);
    step(1);
    chk_irq("coll_irq", 1'b1);
    wr(1'b1, 16'hFF10, 16'h000D);
    chk_rd("clr_flag", 16'hFF10, 16'h0005);
    chk_irq("clr_irq_lag", 1'b1);
    step(1);
    chk_irq("clr_irq_low", 1'b0);
    wr(1'b1, 16'hFF10, 16'h0000);

    // One-shot ch1: PRESCALE=0, RELOAD=4.
    wr(1'b1, 16'hFF15, 16'h0000);
    wr(1'b1, 16'hFF16, 16'h0004);
    wr(1'b1, 16'hFF14, 16'h0007);
    step(3);
    chk_rd("os_count3", 16'hFF17, 16'h0003);
    chk_rd("os_no_flag", 16'hFF14, 16'h0007);
    step(1);
    chk_rd("os_stopped", 16'hFF14, 16'h000E);
    chk_rd("os_count0", 16'hFF17, 16'h0000);
    step(1);
    chk_irq("os_irq", 1'b1);
    wr(1'b1, 16'hFF14, 16'h000E);
    step(50);
    chk_rd("os_no_refire", 16'hFF14, 16'h0006);
    chk_rd("os_count_hold", 16'hFF17, 16'h0000);
    chk_irq("os_irq_low", 1'b0);

    // Isolation: ch1 counts 0..4 while ch0 and out-of-window writes happen.
    wr(1'b1, 16'hFF15, 16'h0000);
    wr(1'b1, 16'hFF16, 16'h0005);
    wr(1'b1, 16'hFF14, 16'h0001);
    for (int k = 0; k < 12; k++) begin
      chk_rd($sformatf("iso_count%0d", k), 16'hFF17, 16'(k % 5));
      case (k % 4)
        0:       wr(1'b1, 16'hFF11, 16'(k));
        1:       wr(1'b1, 16'hFF12, 16'(k + 1));
        2:       wr(1'b0, 16'hFF15, 16'h0003);
        default: wr(1'b1, 16'hFF18, 16'h0003);
      endcase
    end
    wr(1'b1, 16'hFF14, 16'h0000);

    // RELOAD=0 with run=1: counters hold, no events.
    wr(1'b1, 16'hFF11, 16'h0000);
    wr(1'b1, 16'hFF12, 16'h0000);
    wr(1'b1, 16'hFF10, 16'h0005);
    step(100);
    chk_rd("rl0_no_flag", 16'hFF10, 16'h0005);
    chk_rd("rl0_count", 16'hFF13, 16'h0000);
    chk_irq("rl0_irq", 1'b0);

    // Maximum prescaler: first event on the 65536th edge after the start.
    wr(1'b1, 16'hFF10, 16'h0000);
    wr(1'b1, 16'hFF11, 16'hFFFF);
    wr(1'b1, 16'hFF12, 16'h0001);
    wr(1'b1, 16'hFF10, 16'h0005);
    step(65535);
    chk_rd("max_pre_before", 16'hFF10, 16'h0005);
    step(1);
    chk_rd("max_pre_event", 16'hFF10, 16'h000D);

    // Asynchronous reset in the middle of a count.
    wr(1'b1, 16'hFF10, 16'h0004);
    wr(1'b1, 16'hFF11, 16'h0000);
    wr(1'b1, 16'hFF12, 16'h0005);
    wr(1'b1, 16'hFF10, 16'h0005);
    step(2);
    chk_rd("pre_rst_count", 16'hFF13, 16'h0002);
    chk_irq("pre_rst_irq", 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk_irq("async_rst_irq", 1'b0);
    for (int r = 0; r < 8; r++) begin
      chk_rd($sformatf("async_rst_reg%0d", r), 16'hFF10 + 16'(r), 16'h0000);
    end
    step(1);
    reset = 1'b0;
    step(2);
    chk_rd("post_rst_count", 16'hFF13, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
